channel_accumulator_stream: RTL and testbench

//  Streaming successor to the all-channel-parallel conv channel accumulator. Each beat carries one

---
 rtl/channel_accumulator_stream_pkg.sv | 23 ++
 rtl/channel_accumulator_stream_lane.sv | 38 +++
 rtl/channel_accumulator_stream.sv | 107 ++++++++++
 tb/tb_channel_accumulator_stream.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_accumulator_stream_pkg.sv
// Shared defaults and elaboration-time helpers for the streaming channel accumulator.
// The width defaults mirror the layer-1 conv datapath that feeds this block.
package channel_accumulator_stream_pkg;

  localparam int KERNEL_ACCUM_BITWIDTH = 20;
  localparam int BIAS_BITWIDTH         = 16;
  localparam int INPUT_CHANNELS        = 4;
  localparam int OUTPUT_BITWIDTH       = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/channel_accumulator_stream_lane.sv
// One output lane of requantisation: optional ReLU, floor shift, signed saturation.
// Purely combinational; the top registers its outputs.
module acc_requant_lane
  import channel_accumulator_stream_pkg::*;
#(
  parameter int ACC_W     = 23,
  parameter int OUT_W     = OUTPUT_BITWIDTH,
  parameter int OUT_SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] i_sum,
  input  logic                    i_relu,
  output logic [OUT_W-1:0]        o_data,
  output logic                    o_sat
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  logic signed [ACC_W-1:0] w_relu;
  logic signed [ACC_W-1:0] w_shift;

  assign w_relu  = (i_relu && i_sum[ACC_W-1]) ? '0 : i_sum;
  assign w_shift = w_relu >>> OUT_SHIFT;

  // Saturate only when the shifted value leaves the signed output range.
  always_comb begin
    o_data = w_shift[OUT_W-1:0];
    o_sat  = 1'b0;
    if (w_shift > MAX_V) begin
      o_data = MAX_V[OUT_W-1:0];
      o_sat  = 1'b1;
    end else if (w_shift < MIN_V) begin
      o_data = MIN_V[OUT_W-1:0];
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/channel_accumulator_stream.sv
// Time-multiplexed channel accumulator: sums CHANNELS beats per group plus bias,
// then requantises each lane; valid/ready on both sides with a single output register.
module channel_accumulator_stream
  import channel_accumulator_stream_pkg::*;
#(
  parameter int CHANNELS  = INPUT_CHANNELS,
  parameter int LANES     = 2,
  parameter int PSUM_W    = KERNEL_ACCUM_BITWIDTH,
  parameter int BIAS_W    = BIAS_BITWIDTH,
  parameter int OUT_W     = OUTPUT_BITWIDTH,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    cfg_relu,
  input  logic [BIAS_W-1:0]       bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PSUM_W*LANES-1:0] in_psum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W*LANES-1:0]  out_data,
  output logic [LANES-1:0]        out_sat,
  output logic                    busy
);

  localparam int ACC_W = maxInt(PSUM_W, BIAS_W) + clog2(CHANNELS) + 1;
  localparam int CNT_W = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNELS - 1);

  logic [CNT_W-1:0]        r_chCnt;
  logic signed [ACC_W-1:0] r_acc [LANES];
  logic                    r_outValid;
  logic [OUT_W*LANES-1:0]  r_outData;
  logic [LANES-1:0]        r_outSat;

  logic                    w_first;
  logic                    w_last;
  logic                    w_accept;
  logic                    w_load;
  logic signed [ACC_W-1:0] w_sum [LANES];
  logic [OUT_W*LANES-1:0]  w_qData;
  logic [LANES-1:0]        w_qSat;

  assign w_first = (r_chCnt == '0);
  assign w_last  = (r_chCnt == LAST_CH);
  // Only the final beat needs the output register, so only it can stall.
  assign in_ready = !(w_last && r_outValid && !out_ready);
  assign w_accept = in_valid && in_ready && !clear;
  assign w_load   = w_accept && w_last;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic signed [ACC_W-1:0] w_base;
      logic signed [ACC_W-1:0] w_psum;

      assign w_psum = {{(ACC_W-PSUM_W){in_psum[k*PSUM_W+PSUM_W-1]}}, in_psum[k*PSUM_W +: PSUM_W]};
      assign w_base = w_first ? {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias} : r_acc[k];
      assign w_sum[k] = w_base + w_psum;

      acc_requant_lane #(
        .ACC_W    (ACC_W),
        .OUT_W    (OUT_W),
        .OUT_SHIFT(OUT_SHIFT)
      ) u_requant (
        .i_sum (w_sum[k]),
        .i_relu(cfg_relu),
        .o_data(w_qData[k*OUT_W +: OUT_W]),
        .o_sat (w_qSat[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chCnt <= '0;
      for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
    end else if (clear) begin
      r_chCnt <= '0;
    end else if (w_accept) begin
      r_chCnt <= w_last ? '0 : r_chCnt + 1'b1;
      for (int k = 0; k < LANES; k++) r_acc[k] <= w_sum[k];
    end
  end

  // A new result may load in the same cycle the old one is taken, keeping out_valid high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outSat   <= '0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_outData  <= w_qData;
      r_outSat   <= w_qSat;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_sat   = r_outSat;
  assign busy      = (r_chCnt != '0);

endmodule

// File: tb/tb_channel_accumulator_stream.sv
// Self-checking bench: vector table, hand-written handshake/clear/reset sequences and
// randomized traffic against a transaction-level group-sum model (shift 0 and shift 2 DUTs).
module tb_channel_accumulator_stream;

  localparam int CH = 4;
  localparam int PW = 20;

  logic        clk = 1'b0;
  logic        resetN;
  logic        clear;
  logic        cfgRelu;
  logic [15:0] bias;
  logic        inValid;
  logic [39:0] inPsum;
  logic        outReady;

  logic        inReady, outValid, busy;
  logic [15:0] outData;
  logic [1:0]  outSat;
  logic        inReadyS, outValidS, busyS;
  logic [15:0] outDataS;
  logic [1:0]  outSatS;

  always #5 clk = ~clk;

  channel_accumulator_stream #(.CHANNELS(4), .LANES(2), .PSUM_W(20), .BIAS_W(16), .OUT_W(8), .OUT_SHIFT(0)) dut (
    .clk(clk), .reset_n(resetN), .clear(clear), .cfg_relu(cfgRelu), .bias(bias),
    .in_valid(inValid), .in_ready(inReady), .in_psum(inPsum),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_sat(outSat), .busy(busy)
  );

  channel_accumulator_stream #(.CHANNELS(4), .LANES(2), .PSUM_W(20), .BIAS_W(16), .OUT_W(8), .OUT_SHIFT(2)) dutS (
    .clk(clk), .reset_n(resetN), .clear(clear), .cfg_relu(cfgRelu), .bias(bias),
    .in_valid(inValid), .in_ready(inReadyS), .in_psum(inPsum),
    .out_valid(outValidS), .out_ready(outReady), .out_data(outDataS), .out_sat(outSatS), .busy(busyS)
  );

  typedef struct {
    logic [7:0] d0, d1;
    logic [1:0] sat;
    logic [7:0] s0, s1;
    logic [1:0] ssat;
  } res_t;

  typedef struct {
    int         bias;
    int         l0[4];
    int         l1[4];
    bit         relu;
    int         e0, e1;
    logic [1:0] eSat;
    int         s0, s1;
    logic [1:0] sSat;
  } vec_t;

  int     nChecks = 0;
  int     nFails  = 0;
  int     mCnt;
  longint mAcc[2];
  res_t   mQ[$];
  bit     mAccepted;
  int     p0, p1;
  vec_t   vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requantise a group sum straight from its arithmetic definition (floor division, clamp).
  function automatic void requant(input longint s, input bit relu, input int sh,
                                  output logic [7:0] d, output logic sat);
    longint r, dv;
    r  = (relu && s < 0) ? 0 : s;
    dv = longint'(1) << sh;
    if (r >= 0) r = r / dv;
    else        r = -((-r + dv - 1) / dv);
    sat = 1'b0;
    if (r > 127)       begin r = 127;  sat = 1'b1; end
    else if (r < -128) begin r = -128; sat = 1'b1; end
    d = 8'(r);
  endfunction

  task automatic resetModel();
    mCnt = 0;
    mAcc[0] = 0;
    mAcc[1] = 0;
    mQ.delete();
  endtask

  task automatic setBeat(input bit v, input int b, input int a0, input int a1, input bit relu);
    inValid = v;
    bias    = 16'(b);
    p0      = a0;
    p1      = a1;
    inPsum  = {PW'(a1), PW'(a0)};
    cfgRelu = relu;
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic applyStimulus();
    bit     expReady, hs;
    res_t   r;
    longint base;
    logic   st;
    #1;
    expReady = !(mCnt == CH-1 && mQ.size() > 0 && !outReady);
    checkOutput("in_ready", 32'(inReady), 32'(expReady));
    checkOutput("in_ready_s2", 32'(inReadyS), 32'(expReady));
    checkOutput("out_valid", 32'(outValid), 32'(mQ.size() > 0));
    checkOutput("out_valid_s2", 32'(outValidS), 32'(mQ.size() > 0));
    checkOutput("busy", 32'(busy), 32'(mCnt != 0));
    if (mQ.size() > 0) begin
      checkOutput("out_data", 32'(outData), 32'({mQ[0].d1, mQ[0].d0}));
      checkOutput("out_sat", 32'(outSat), 32'(mQ[0].sat));
      checkOutput("out_data_s2", 32'(outDataS), 32'({mQ[0].s1, mQ[0].s0}));
      checkOutput("out_sat_s2", 32'(outSatS), 32'(mQ[0].ssat));
    end
    hs = inValid && expReady;
    mAccepted = hs && !clear;
    @(posedge clk);
    if (mQ.size() > 0 && outReady) void'(mQ.pop_front());
    if (clear) begin
      mCnt = 0;
    end else if (hs) begin
      for (int l = 0; l < 2; l++) begin
        base = (mCnt == 0) ? longint'($signed(bias)) : mAcc[l];
        mAcc[l] = base + longint'((l == 0) ? p0 : p1);
      end
      if (mCnt == CH-1) begin
        requant(mAcc[0], cfgRelu, 0, r.d0, st); r.sat[0] = st;
        requant(mAcc[1], cfgRelu, 0, r.d1, st); r.sat[1] = st;
        requant(mAcc[0], cfgRelu, 2, r.s0, st); r.ssat[0] = st;
        requant(mAcc[1], cfgRelu, 2, r.s1, st); r.ssat[1] = st;
        mQ.push_back(r);
        mCnt = 0;
      end else begin
        mCnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic sendBeat(input int b, input int a0, input int a1, input bit relu);
    int n;
    setBeat(1'b1, b, a0, a1, relu);
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!mAccepted && n < 20);
    if (!mAccepted) checkOutput("accept_timeout", 32'(0), 32'(1));
    inValid = 1'b0;
  endtask

  task automatic runVector(input int idx);
    outReady = 1'b1;
    for (int b = 0; b < 4; b++) sendBeat(vecs[idx].bias, vecs[idx].l0[b], vecs[idx].l1[b], vecs[idx].relu);
    checkOutput($sformatf("vec%0d_valid", idx), 32'(outValid), 32'(1));
    checkOutput($sformatf("vec%0d_data", idx), 32'(outData), 32'({8'(vecs[idx].e1), 8'(vecs[idx].e0)}));
    checkOutput($sformatf("vec%0d_sat", idx), 32'(outSat), 32'(vecs[idx].eSat));
    checkOutput($sformatf("vec%0d_data_s2", idx), 32'(outDataS), 32'({8'(vecs[idx].s1), 8'(vecs[idx].s0)}));
    checkOutput($sformatf("vec%0d_sat_s2", idx), 32'(outSatS), 32'(vecs[idx].sSat));
    applyStimulus();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{5, '{1, 2, 3, 4}, '{-10, -10, -10, -10}, 1'b0, 15, -35, 2'b00, 3, -9, 2'b00};
    vecs[1] = '{5, '{1, 2, 3, 4}, '{-10, -10, -10, -10}, 1'b1, 15, 0, 2'b00, 3, 0, 2'b00};
    vecs[2] = '{0, '{100, 100, 100, 100}, '{-100, -100, -100, -100}, 1'b0, 127, -128, 2'b11, 100, -100, 2'b00};
    vecs[3] = '{0, '{15, 0, 0, 0}, '{-15, 0, 0, 0}, 1'b0, 15, -15, 2'b00, 3, -4, 2'b00};
    vecs[4] = '{32767, '{524287, 524287, 524287, 524287}, '{-524288, -524288, -524288, -524288}, 1'b0,
                127, -128, 2'b11, 127, -128, 2'b11};
    vecs[5] = '{0, '{127, 0, 0, 0}, '{-128, 0, 0, 0}, 1'b0, 127, -128, 2'b00, 31, -32, 2'b00};
    vecs[6] = '{0, '{128, 0, 0, 0}, '{-129, 0, 0, 0}, 1'b0, 127, -128, 2'b11, 32, -33, 2'b00};
    vecs[7] = '{-3, '{-1, -1, -1, -1}, '{2, 2, 2, 2}, 1'b1, 0, 5, 2'b00, 0, 1, 2'b00};

    resetN = 1'b1;
    clear = 1'b0;
    outReady = 1'b0;
    setBeat(1'b0, 0, 0, 0, 1'b0);
    #2 resetN = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(outValid), 32'(0));
    checkOutput("rst_out_data", 32'(outData), 32'(0));
    checkOutput("rst_out_sat", 32'(outSat), 32'(0));
    checkOutput("rst_in_ready", 32'(inReady), 32'(1));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    resetN = 1'b1;
    resetModel();
    @(negedge clk);

    for (int i = 0; i < 8; i++) runVector(i);

    // Output held while a second group streams in; only its final beat stalls.
    outReady = 1'b0;
    for (int b = 0; b < 4; b++) sendBeat(1, 10, -1, 1'b0);
    for (int b = 0; b < 3; b++) sendBeat(0, 2, 3, 1'b0);
    checkOutput("t4_busy", 32'(busy), 32'(1));
    setBeat(1'b1, 0, 2, 3, 1'b0);
    repeat (3) applyStimulus();
    checkOutput("t4_in_ready_stall", 32'(inReady), 32'(0));
    checkOutput("t4_held_data", 32'(outData), 32'({8'(-3), 8'(41)}));
    outReady = 1'b1;
    applyStimulus();
    inValid = 1'b0;
    checkOutput("t4_no_bubble", 32'(outValid), 32'(1));
    checkOutput("t4_group2", 32'(outData), 32'({8'(12), 8'(8)}));
    applyStimulus();

    // Clear mid-group, then clear colliding with an accepted beat.
    sendBeat(7, 50, 50, 1'b0);
    sendBeat(7, 50, 50, 1'b0);
    clear = 1'b1;
    applyStimulus();
    clear = 1'b0;
    checkOutput("t5_clear_busy", 32'(busy), 32'(0));
    for (int b = 0; b < 4; b++) sendBeat(0, 1, 1, 1'b0);
    checkOutput("t5_after_clear", 32'(outData), 32'({8'(4), 8'(4)}));
    applyStimulus();
    clear = 1'b1;
    setBeat(1'b1, 0, 9, 9, 1'b0);
    applyStimulus();
    clear = 1'b0;
    inValid = 1'b0;
    checkOutput("t5_drop_busy", 32'(busy), 32'(0));
    for (int b = 0; b < 4; b++) sendBeat(0, 2, 2, 1'b0);
    checkOutput("t5_drop_result", 32'(outData), 32'({8'(8), 8'(8)}));
    applyStimulus();

    // Asynchronous reset in the middle of a group with a result still held.
    outReady = 1'b0;
    for (int b = 0; b < 4; b++) sendBeat(0, 3, 3, 1'b0);
    sendBeat(0, 3, 3, 1'b0);
    sendBeat(0, 3, 3, 1'b0);
    checkOutput("t6_pre_valid", 32'(outValid), 32'(1));
    resetN = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(outValid), 32'(0));
    checkOutput("t6_rst_data", 32'(outData), 32'(0));
    checkOutput("t6_rst_sat", 32'(outSat), 32'(0));
    checkOutput("t6_rst_busy", 32'(busy), 32'(0));
    resetModel();
    @(negedge clk);
    resetN = 1'b1;
    outReady = 1'b1;
    for (int b = 0; b < 4; b++) sendBeat(1, 1, 0, 1'b0);
    checkOutput("t6_restart", 32'(outData), 32'({8'(1), 8'(5)}));
    applyStimulus();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      int a0, a1;
      a0 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 400)) - 200
                                       : int'($urandom_range(0, 1048575)) - 524288;
      a1 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 400)) - 200
                                       : int'($urandom_range(0, 1048575)) - 524288;
      setBeat($urandom_range(0, 3) != 0, int'($signed(16'($urandom))), a0, a1, $urandom_range(0, 1) != 0);
      outReady = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 39) == 0);
      applyStimulus();
    end
    clear = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    repeat (3) applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
